// File: rtl/psum_collector.sv
// Collects the bottom-row partial sums of the systolic array, removes the
// per-column diagonal skew, binarizes each sum and queues complete rows.
module psum_collector #(
    parameter int COLS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      partialsum_in_valid,
    input  logic [16*COLS-1:0]   partialsum_in,
    input  logic                 clear_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*COLS-1:0]   out_data,
    output logic [COLS-1:0]      out_bits,
    output logic                 overflow,
    output logic                 skew_error,
    output logic [15:0]          row_count
);

    localparam int AW = $clog2(DEPTH);

    logic [16*COLS-1:0] aligned_row;
    logic [COLS-1:0]    aligned_valid;
    logic [COLS-1:0]    aligned_bits;

    // Earlier columns wait longer so that every column of a row lines up
    // with the moment the last column arrives.
    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == COLS - 1) begin : g_pass
                assign aligned_row[16*c +: 16] = partialsum_in[16*c +: 16];
                assign aligned_valid[c]        = partialsum_in_valid[c];
            end else begin : g_dly
                localparam int LEN = COLS - 1 - c;
                logic [15:0]    dly_data [LEN];
                logic [LEN-1:0] dly_valid;

                always_ff @(posedge clk) begin
                    dly_data[0] <= partialsum_in[16*c +: 16];
                    for (int k = 1; k < LEN; k++) begin
                        dly_data[k] <= dly_data[k-1];
                    end
                    if (rst) begin
                        dly_valid <= '0;
                    end else begin
                        dly_valid[0] <= partialsum_in_valid[c];
                        for (int k = 1; k < LEN; k++) begin
                            dly_valid[k] <= dly_valid[k-1];
                        end
                    end
                end

                assign aligned_row[16*c +: 16] = dly_data[LEN-1];
                assign aligned_valid[c]        = dly_valid[LEN-1];
            end
        end
    endgenerate

    // Both signed zeros count as non-negative activations.
    always_comb begin
        aligned_bits = '0;
        for (int c = 0; c < COLS; c++) begin
            aligned_bits[c] = ~aligned_row[16*c+15] | (aligned_row[16*c +: 15] == 15'd0);
        end
    end

    logic complete;
    logic mixed;
    logic full;
    logic pop;
    logic push;

    logic [16*COLS-1:0] mem_data [DEPTH];
    logic [COLS-1:0]    mem_bits [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    assign complete  = ~rst & (&aligned_valid);
    assign mixed     = ~rst & (|aligned_valid) & ~(&aligned_valid);
    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = complete & (~full | pop);

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_bits = out_valid ? mem_bits[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= aligned_row;
            mem_bits[wr_ptr] <= aligned_bits;
        end
    end

    // Flags are set-dominant so a clear never hides an event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            skew_error <= 1'b0;
            row_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                row_count <= row_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            overflow   <= (overflow & ~clear_flags) | (complete & full & ~pop);
            skew_error <= (skew_error & ~clear_flags) | mixed;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: a row-level model (input history window
// plus a row queue) is compared every cycle, with literal checks on top.
module tb_psum_collector;

    localparam int COLS  = 4;
    localparam int DEPTH = 4;
    localparam int W     = 16 * COLS;
    localparam int NCYC  = 32;

    logic            clk;
    logic            rst;
    logic [COLS-1:0] partialsum_in_valid;
    logic [W-1:0]    partialsum_in;
    logic            clear_flags;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [COLS-1:0] out_bits;
    logic            overflow;
    logic            skew_error;
    logic [15:0]     row_count;

    int tests = 0;
    int fails = 0;

    psum_collector #(.COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .partialsum_in_valid (partialsum_in_valid),
        .partialsum_in       (partialsum_in),
        .clear_flags         (clear_flags),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_bits            (out_bits),
        .overflow            (overflow),
        .skew_error          (skew_error),
        .row_count           (row_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle stimulus schedule.
    logic [COLS-1:0] s_valid [NCYC];
    logic [W-1:0]    s_data  [NCYC];
    logic            s_ready [NCYC];
    logic            s_clr   [NCYC];
    logic            s_rst   [NCYC];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rowval(input int r, input int c);
        return ((r % 2) != 0 ? 16'h8000 : 16'h0000) | 16'(r * 16) | 16'(c);
    endfunction

    function automatic logic [COLS-1:0] binarize(input logic [W-1:0] row);
        logic [COLS-1:0] b;
        logic [15:0]     v;
        b = '0;
        for (int c = 0; c < COLS; c++) begin
            v = row[16*c +: 16];
            b[c] = (v[15] == 1'b0) || ((v & 16'h7FFF) == 16'h0000);
        end
        return b;
    endfunction

    task automatic clearSchedule();
        for (int i = 0; i < NCYC; i++) begin
            s_valid[i] = '0;
            s_data[i]  = '0;
            s_ready[i] = 1'b0;
            s_clr[i]   = 1'b0;
            s_rst[i]   = 1'b0;
        end
    endtask

    task automatic addRaw(input int cyc, input int c, input logic [15:0] val);
        s_valid[cyc][c]        = 1'b1;
        s_data[cyc][16*c +: 16] = val;
    endtask

    // Column c of a row is presented c cycles after column 0.
    task automatic addRow(input int start, input int r, input logic [COLS-1:0] mask);
        for (int c = 0; c < COLS; c++) begin
            if (mask[c]) addRaw(start + c, c, rowval(r, c));
        end
    endtask

    task automatic setReady(input int first, input int last_excl);
        for (int i = first; i < last_excl; i++) s_ready[i] = 1'b1;
    endtask

    // Drives cycles [first, last_excl) of the schedule, one per negedge.
    task automatic applyStimulus(input int first, input int last_excl);
        for (int i = first; i < last_excl; i++) begin
            rst                 = s_rst[i];
            partialsum_in_valid = s_valid[i];
            partialsum_in       = s_data[i];
            out_ready           = s_ready[i];
            clear_flags         = s_clr[i];
            @(negedge clk);
        end
        rst                 = 1'b0;
        partialsum_in_valid = '0;
        partialsum_in       = '0;
        out_ready           = 1'b0;
        clear_flags         = 1'b0;
    endtask

    task automatic doReset();
        rst                 = 1'b1;
        partialsum_in_valid = '0;
        partialsum_in       = '0;
        out_ready           = 1'b0;
        clear_flags         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Row-level model: column c of the aligned row is whatever was presented
    // COLS-1-c cycles ago, unless a reset intervened.
    logic [COLS-1:0] hist_v [COLS];
    logic [W-1:0]    hist_d [COLS];
    logic [W-1:0]    model_q [$];
    logic            m_ov;
    logic            m_sk;
    logic [15:0]     m_cnt;
    logic            checking = 1'b0;

    always @(posedge clk) begin
        logic [COLS-1:0] al_v;
        logic [W-1:0]    al_d;
        int              n;
        logic            m_pop;
        logic            m_full;
        if (rst) begin
            model_q.delete();
            m_ov     = 1'b0;
            m_sk     = 1'b0;
            m_cnt    = 16'd0;
            checking = 1'b1;
            for (int k = 0; k < COLS; k++) begin
                hist_v[k] = '0;
                hist_d[k] = '0;
            end
        end else begin
            for (int k = COLS - 1; k > 0; k--) begin
                hist_v[k] = hist_v[k-1];
                hist_d[k] = hist_d[k-1];
            end
            hist_v[0] = partialsum_in_valid;
            hist_d[0] = partialsum_in;
            al_v = '0;
            al_d = '0;
            for (int c = 0; c < COLS; c++) begin
                al_v[c]          = hist_v[COLS-1-c][c];
                al_d[16*c +: 16] = hist_d[COLS-1-c][16*c +: 16];
            end
            n      = $countones(al_v);
            m_pop  = (model_q.size() > 0) && out_ready;
            m_full = (model_q.size() == DEPTH);
            if (clear_flags) begin
                m_ov = 1'b0;
                m_sk = 1'b0;
            end
            if (n == COLS && m_full && !m_pop) m_ov = 1'b1;
            if (n != 0 && n != COLS) m_sk = 1'b1;
            if (m_pop) void'(model_q.pop_front());
            if (n == COLS && (!m_full || m_pop)) begin
                model_q.push_back(al_d);
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_data;
        if (checking) begin
            exp_data = (model_q.size() > 0) ? model_q[0] : '0;
            checkOutput("model out_valid", out_valid, model_q.size() > 0);
            checkOutput("model out_data", out_data, exp_data);
            checkOutput("model out_bits", out_bits, (model_q.size() > 0) ? binarize(exp_data) : '0);
            checkOutput("model overflow", overflow, m_ov);
            checkOutput("model skew_error", skew_error, m_sk);
            checkOutput("model row_count", row_count, m_cnt);
        end
    end

    initial begin
        clearSchedule();
        doReset();
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out_data", out_data, 64'h0);
        checkOutput("reset row_count", row_count, 16'd0);

        // Single row with signed zeros and negative values.
        clearSchedule();
        addRaw(0, 0, 16'h3C00);
        addRaw(1, 1, 16'hBC00);
        addRaw(2, 2, 16'h0000);
        addRaw(3, 3, 16'h8000);
        applyStimulus(0, 3);
        checkOutput("single early out_valid", out_valid, 1'b0);
        applyStimulus(3, 4);
        checkOutput("single out_valid", out_valid, 1'b1);
        checkOutput("single out_data", out_data, 64'h8000_0000_BC00_3C00);
        checkOutput("single out_bits", out_bits, 4'b1101);
        checkOutput("single row_count", row_count, 16'd1);
        applyStimulus(4, 6);

        // Back-to-back rows with a ready consumer.
        doReset();
        clearSchedule();
        for (int r = 0; r < 8; r++) addRow(r, r + 1, 4'b1111);
        setReady(0, 16);
        applyStimulus(0, 4);
        checkOutput("b2b first head", out_data[15:0], 16'h8010);
        applyStimulus(4, 16);
        checkOutput("b2b row_count", row_count, 16'd8);
        checkOutput("b2b overflow", overflow, 1'b0);
        checkOutput("b2b skew_error", skew_error, 1'b0);

        // Overflow: five rows into a four-deep FIFO with no consumer.
        doReset();
        clearSchedule();
        for (int r = 0; r < 5; r++) addRow(r, r + 1, 4'b1111);
        applyStimulus(0, 10);
        checkOutput("ovf overflow", overflow, 1'b1);
        checkOutput("ovf row_count", row_count, 16'd4);
        checkOutput("ovf head", out_data[15:0], 16'h8010);
        clearSchedule();
        setReady(0, 6);
        applyStimulus(0, 6);
        checkOutput("ovf drained", out_valid, 1'b0);
        checkOutput("ovf drain row_count", row_count, 16'd4);

        // Full FIFO with a pop in the same cycle as the fifth write.
        doReset();
        clearSchedule();
        for (int r = 0; r < 4; r++) addRow(r, r + 1, 4'b1111);
        addRow(10, 5, 4'b1111);
        setReady(13, 14);
        applyStimulus(0, 15);
        checkOutput("fullpop overflow", overflow, 1'b0);
        checkOutput("fullpop row_count", row_count, 16'd5);
        checkOutput("fullpop head", out_data, {rowval(2, 3), rowval(2, 2), rowval(2, 1), rowval(2, 0)});

        // Skew error, clear, then clear coinciding with a new error.
        doReset();
        clearSchedule();
        addRow(0, 1, 4'b1011);
        applyStimulus(0, 6);
        checkOutput("skew set", skew_error, 1'b1);
        checkOutput("skew row_count", row_count, 16'd0);
        checkOutput("skew no write", out_valid, 1'b0);
        clearSchedule();
        s_clr[0] = 1'b1;
        applyStimulus(0, 2);
        checkOutput("skew cleared", skew_error, 1'b0);
        clearSchedule();
        addRow(0, 2, 4'b1011);
        s_clr[3] = 1'b1;
        applyStimulus(0, 5);
        checkOutput("skew set dominant", skew_error, 1'b1);

        // Reset in the middle of a row, then a clean row afterwards.
        doReset();
        clearSchedule();
        addRow(0, 3, 4'b0011);
        s_rst[2] = 1'b1;
        applyStimulus(0, 8);
        checkOutput("midrst out_valid", out_valid, 1'b0);
        checkOutput("midrst out_data", out_data, 64'h0);
        checkOutput("midrst skew_error", skew_error, 1'b0);
        checkOutput("midrst row_count", row_count, 16'd0);
        clearSchedule();
        addRow(0, 4, 4'b1111);
        applyStimulus(0, 3);
        checkOutput("midrst latency early", out_valid, 1'b0);
        applyStimulus(3, 4);
        checkOutput("midrst latency on time", out_valid, 1'b1);
        checkOutput("midrst row_count after", row_count, 16'd1);
        applyStimulus(4, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
